// File: rtl/drums_pkg.sv
// drums_pkg: shared constants for the Drums Hero score display (digit count, BCD limit, anode idle pattern)
package drums_pkg;
    localparam int         NUM_DIG   = 4;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] ANODO_OFF = 4'b1111;
endpackage

// File: rtl/marcador_bcd_multiplexado_if.sv
// marcador_bcd_multiplexado_if: score/display bus; master drives inc/clr, slave returns digit_out, anodo, score_bcd, saturado
interface marcador_bcd_multiplexado_if;
    logic        inc;
    logic        clr;
    logic [3:0]  digit_out;
    logic [3:0]  anodo;
    logic [15:0] score_bcd;
    logic        saturado;
    modport master (output inc, clr, input digit_out, anodo, score_bcd, saturado);
    modport slave  (input inc, clr, output digit_out, anodo, score_bcd, saturado);
endinterface

// File: rtl/contador_bcd_digito.sv
// contador_bcd_digito: one BCD digit (clk, rst_n, en, clr, carry_in -> q[3:0], carry_out), wraps 9->0 with carry
module contador_bcd_digito
    import drums_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       carry_in,
    output logic [3:0] q,
    output logic       carry_out
);
    assign carry_out = en & carry_in & (q == BCD_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 4'd0;
        else if (clr) q <= 4'd0;
        else if (en & carry_in) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/marcador_bcd_multiplexado.sv
// marcador_bcd_multiplexado: saturating 4-digit BCD score counter with multiplexed display scan
// Ports: clk, rst_n (async active-low), bus.slave (inc, clr in; digit_out, anodo, score_bcd, saturado out)
module marcador_bcd_multiplexado
    import drums_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input logic                          clk,
    input logic                          rst_n,
    marcador_bcd_multiplexado_if.slave   bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [15:0]        w_score;
    logic [NUM_DIG:0]   w_c;
    logic               w_c_unused;
    logic               w_full;
    logic               w_tick;
    logic [3:1]         w_zero;
    logic [3:0]         w_blank;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_digit;
    logic [3:0]         r_anodo;
    logic               r_sat;
    assign w_c[0]     = 1'b1;
    assign w_c_unused = w_c[NUM_DIG];
    assign w_full     = (w_score == 16'h9999);
    assign w_tick     = (r_cnt == CW'(REFRESH_DIV - 1));
    // Counting is frozen at 9999 so the chain never wraps to 0000
    for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
        contador_bcd_digito u_dig (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (bus.inc & ~w_full),
            .clr       (bus.clr),
            .carry_in  (w_c[d]),
            .q         (w_score[4*d +: 4]),
            .carry_out (w_c[d+1])
        );
        if (d > 0) begin : g_z
            assign w_zero[d] = (w_score[4*d +: 4] == 4'd0);
        end
    end
    // A digit is a leading zero only if it and every digit above it are zero; units always lit
    assign w_blank[3] = BLANK_ZEROS & w_zero[3];
    assign w_blank[2] = w_blank[3] & w_zero[2];
    assign w_blank[1] = w_blank[2] & w_zero[1];
    assign w_blank[0] = 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_digit <= 4'd0;
            r_anodo <= ANODO_OFF;
            r_sat   <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_idx   <= w_tick ? r_idx + 2'd1 : r_idx;
            r_digit <= w_score[{r_idx, 2'b00} +: 4];
            r_anodo <= w_blank[r_idx] ? ANODO_OFF : ~(4'b0001 << r_idx);
            r_sat   <= bus.clr ? 1'b0 : (r_sat | (bus.inc & w_full));
        end
    end
    assign bus.score_bcd = w_score;
    assign bus.digit_out = r_digit;
    assign bus.anodo     = r_anodo;
    assign bus.saturado  = r_sat;
endmodule

// File: tb/tb_marcador_bcd_multiplexado.sv
// tb_marcador_bcd_multiplexado: directed vectors for counting, saturation, clear, async reset and display scan
module tb_marcador_bcd_multiplexado;
    localparam int RD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    marcador_bcd_multiplexado_if ifa ();
    marcador_bcd_multiplexado_if ifb ();
    assign ifb.inc = ifa.inc;
    assign ifb.clr = ifa.clr;
    marcador_bcd_multiplexado #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    marcador_bcd_multiplexado #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    typedef struct {
        logic        inc;
        logic        clr;
        logic        rst;
        int          n;
        logic [15:0] score;
        logic        sat;
        string       nm;
    } vec_t;
    vec_t v[15];
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Stops on the first cycle of slot 0 output (anodo entering 1110)
    task automatic align();
        logic [3:0] prev;
        bit ok;
        ok = 1'b0;
        prev = ifa.anodo;
        for (int k = 0; k < 40 && !ok; k++) begin
            step(1);
            if (prev != 4'b1110 && ifa.anodo == 4'b1110) ok = 1'b1;
            prev = ifa.anodo;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL align: got no slot-0 start expected one within 40 cycles");
        end
    endtask
    task automatic scan(input string tag, input logic [15:0] score,
                        input logic [3:0] anA [4], input logic [3:0] anB [4], input bit use_b);
        align();
        for (int i = 0; i <= 16; i++) begin
            int s;
            s = (i / 4) % 4;
            chk($sformatf("%s anodo c%0d", tag, i), {12'h0, ifa.anodo}, {12'h0, anA[s]});
            chk($sformatf("%s digit c%0d", tag, i), {12'h0, ifa.digit_out}, {12'h0, score[4*s +: 4]});
            if (use_b) begin
                chk($sformatf("%s nb anodo c%0d", tag, i), {12'h0, ifb.anodo}, {12'h0, anB[s]});
                chk($sformatf("%s nb digit c%0d", tag, i), {12'h0, ifb.digit_out}, {12'h0, score[4*s +: 4]});
            end
            step(1);
        end
    endtask
    initial begin
        logic [3:0] an_305 [4];
        logic [3:0] an_0   [4];
        logic [3:0] an_all [4];
        an_305 = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        an_0   = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        an_all = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        v[0]  = '{1'b1, 1'b0, 1'b0, 9,    16'h0009, 1'b0, "inc9"};
        v[1]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0010, 1'b0, "carry10"};
        v[2]  = '{1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, "clr"};
        v[3]  = '{1'b1, 1'b0, 1'b0, 999,  16'h0999, 1'b0, "inc999"};
        v[4]  = '{1'b1, 1'b0, 1'b0, 1,    16'h1000, 1'b0, "carry1000"};
        v[5]  = '{1'b1, 1'b0, 1'b0, 8999, 16'h9999, 1'b0, "to9999"};
        v[6]  = '{1'b1, 1'b0, 1'b0, 1,    16'h9999, 1'b1, "sat1"};
        v[7]  = '{1'b1, 1'b0, 1'b0, 3,    16'h9999, 1'b1, "sat_hold"};
        v[8]  = '{1'b0, 1'b0, 1'b1, 0,    16'h0000, 1'b0, "rst_mid"};
        v[9]  = '{1'b1, 1'b0, 1'b0, 9999, 16'h9999, 1'b0, "pre9999"};
        v[10] = '{1'b1, 1'b0, 1'b0, 1,    16'h9999, 1'b1, "sat2"};
        v[11] = '{1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, "clr_sat"};
        v[12] = '{1'b1, 1'b0, 1'b0, 42,   16'h0042, 1'b0, "inc42"};
        v[13] = '{1'b1, 1'b1, 1'b0, 1,    16'h0000, 1'b0, "clr_inc"};
        v[14] = '{1'b1, 1'b0, 1'b0, 305,  16'h0305, 1'b0, "inc305"};
        ifa.inc = 1'b0;
        ifa.clr = 1'b0;
        step(2);
        chk("reset score", ifa.score_bcd, 16'h0000);
        chk("reset anodo", {12'h0, ifa.anodo}, 16'h000f);
        chk("reset digit", {12'h0, ifa.digit_out}, 16'h0000);
        chk("reset sat", {15'h0, ifa.saturado}, 16'h0000);
        rst_n = 1'b1;
        step(1);
        for (int r = 0; r < 15; r++) begin
            if (v[r].rst) begin
                rst_n = 1'b0;
                #2;
                chk({v[r].nm, " score"}, ifa.score_bcd, v[r].score);
                chk({v[r].nm, " sat"}, {15'h0, ifa.saturado}, {15'h0, v[r].sat});
                chk({v[r].nm, " anodo"}, {12'h0, ifa.anodo}, 16'h000f);
                chk({v[r].nm, " digit"}, {12'h0, ifa.digit_out}, 16'h0000);
                chk({v[r].nm, " nb anodo"}, {12'h0, ifb.anodo}, 16'h000f);
                step(1);
                rst_n = 1'b1;
                step(1);
            end else begin
                ifa.inc = v[r].inc;
                ifa.clr = v[r].clr;
                step(v[r].n);
                ifa.inc = 1'b0;
                ifa.clr = 1'b0;
                chk({v[r].nm, " score"}, ifa.score_bcd, v[r].score);
                chk({v[r].nm, " sat"}, {15'h0, ifa.saturado}, {15'h0, v[r].sat});
                chk({v[r].nm, " nb score"}, ifb.score_bcd, v[r].score);
            end
        end
        scan("s0305", 16'h0305, an_305, an_all, 1'b0);
        ifa.clr = 1'b1;
        step(1);
        ifa.clr = 1'b0;
        chk("zero score", ifa.score_bcd, 16'h0000);
        scan("s0000", 16'h0000, an_0, an_all, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
